// File: rtl/tick_sequence_controller.sv
// Run controller: latches speed/length on Start, paces Tick strobes from a
// reloadable rate divider and counts them down to zero, with pause and abort.
module tick_sequence_controller #(
   parameter int COUNT_W = 4,
   parameter int DIV_W   = 11,
   parameter int RELOAD1 = 499,
   parameter int RELOAD2 = 999,
   parameter int RELOAD3 = 1999
) (
   input  logic               ClockIn,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Pause,
   input  logic               Stop,
   input  logic [1:0]         Speed,
   input  logic [COUNT_W-1:0] LoadValue,
   output logic               Tick,
   output logic [COUNT_W-1:0] CounterValue,
   output logic               Busy,
   output logic               Done,
   output logic [1:0]         State
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]         spd_q, spd_d;
   logic               tick;

   function automatic logic [DIV_W-1:0] reload_of(input logic [1:0] spd);
      case (spd)
         2'b01:   return DIV_W'(RELOAD1);
         2'b10:   return DIV_W'(RELOAD2);
         2'b11:   return DIV_W'(RELOAD3);
         default: return '0;
      endcase
   endfunction

   assign tick = (state_q == RUN) && (div_q == '0);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      spd_d   = spd_q;
      if (Stop) begin
         state_d = IDLE;
         cnt_d   = '0;
         div_d   = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (Start) begin
                  spd_d = Speed;
                  cnt_d = LoadValue;
                  // A zero-length run goes straight to DONE, where the divider rests at 0.
                  if (LoadValue != '0) begin
                     state_d = RUN;
                     div_d   = reload_of(Speed);
                  end else begin
                     state_d = DONE;
                     div_d   = '0;
                  end
               end else begin
                  cnt_d = '0;
                  div_d = '0;
               end
            end
            RUN: begin
               if (tick) begin
                  cnt_d = cnt_q - COUNT_W'(1);
                  div_d = reload_of(spd_q);
                  if (cnt_q == COUNT_W'(1)) begin
                     state_d = DONE;
                     div_d   = '0;
                  end
               end else begin
                  // The divider still advances on the cycle Pause is first seen.
                  div_d = div_q - DIV_W'(1);
                  if (Pause) state_d = PAUSE;
               end
            end
            PAUSE: begin
               if (!Pause) state_d = RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         spd_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         spd_q   <= spd_d;
      end
   end

   assign Tick         = tick;
   assign CounterValue = cnt_q;
   assign Busy         = (state_q == RUN) || (state_q == PAUSE);
   assign Done         = (state_q == DONE);
   assign State        = state_q;

endmodule

// File: tb/tb_tick_sequence_controller.sv
// Scoreboard bench for tick_sequence_controller: a cycle model in terms of
// ticks-remaining and cycles-since-last-tick queues expected outputs per cycle.
module tb_tick_sequence_controller;

   logic       ClockIn = 1'b0;
   logic       Reset   = 1'b1;
   logic       Start   = 1'b0;
   logic       Pause   = 1'b0;
   logic       Stop    = 1'b0;
   logic [1:0] Speed   = 2'b00;
   logic [3:0] LoadValue = 4'd0;
   logic       Tick;
   logic [3:0] CounterValue;
   logic       Busy;
   logic       Done;
   logic [1:0] State;

   int checks   = 0;
   int failures = 0;

   tick_sequence_controller dut (
      .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Pause(Pause), .Stop(Stop),
      .Speed(Speed), .LoadValue(LoadValue), .Tick(Tick), .CounterValue(CounterValue),
      .Busy(Busy), .Done(Done), .State(State)
   );

   always #5 ClockIn = ~ClockIn;

   // Reference model: 0 idle, 1 run, 2 pause, 3 done
   int m_state = 0, m_left = 0, m_R = 0, m_phase = 0;
   logic [8:0] exp_q[$];

   function automatic int rel(input logic [1:0] s);
      case (s)
         2'b01:   return 499;
         2'b10:   return 999;
         2'b11:   return 1999;
         default: return 0;
      endcase
   endfunction

   function automatic logic [8:0] m_out();
      logic t;
      t = (m_state == 1) && (m_phase == m_R);
      return {t, 4'(m_left), (m_state == 1) || (m_state == 2), m_state == 3, 2'(m_state)};
   endfunction

   initial forever begin
      @(posedge ClockIn);
      if (Reset) begin
         m_state = 0; m_left = 0; m_phase = 0; m_R = 0;
      end else if (Stop) begin
         m_state = 0; m_left = 0; m_phase = 0;
      end else begin
         case (m_state)
            0, 3: begin
               if (Start) begin
                  m_R = rel(Speed); m_left = int'(LoadValue); m_phase = 0;
                  m_state = (LoadValue != 4'd0) ? 1 : 3;
               end else m_left = 0;
            end
            1: begin
               if (m_phase == m_R) begin
                  m_left = m_left - 1; m_phase = 0;
                  if (m_left == 0) m_state = 3;
               end else begin
                  m_phase = m_phase + 1;
                  if (Pause) m_state = 2;
               end
            end
            default: if (!Pause) m_state = 1;
         endcase
      end
      exp_q.push_back(m_out());
   end

   // Monitor: outputs are registered, so they are stable at the falling edge.
   initial forever begin
      logic [8:0] e, g;
      @(negedge ClockIn);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {Tick, CounterValue, Busy, Done, State};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL outputs t=%0t got tick=%b cnt=%0d busy=%b done=%b st=%0d want tick=%b cnt=%0d busy=%b done=%b st=%0d",
                     $time, g[8], g[7:4], g[3], g[2], g[1:0], e[8], e[7:4], e[3], e[2], e[1:0]);
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic cyc(input logic st, input logic pa, input logic sp,
                      input logic [1:0] spd, input logic [3:0] lv);
      Start = st; Pause = pa; Stop = sp; Speed = spd; LoadValue = lv;
      @(negedge ClockIn);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 2'($urandom), 4'($urandom));
   endtask

   initial begin
      int first, ticks;
      repeat (3) @(negedge ClockIn);
      Reset = 1'b0;
      idle(2);

      // Fast run, then zero-length run
      cyc(1, 0, 0, 2'b00, 4'd3); idle(6);
      cyc(1, 0, 0, 2'b00, 4'd0); idle(3);

      // Speed 01, length 2; live Speed toggled mid-run
      cyc(1, 0, 0, 2'b01, 4'd2);
      first = 0; ticks = 0;
      for (int i = 1; i <= 1100; i++) begin
         if (Tick && first == 0) first = i;
         if (Tick) ticks++;
         Start = 1'b0; Speed = 2'($urandom);
         @(negedge ClockIn);
      end
      chk("speed1_first_tick", first, 500);
      chk("speed1_tick_count", ticks, 2);

      // Speed 10 with a 50-cycle pause inside the first interval
      cyc(1, 0, 0, 2'b10, 4'd2);
      first = 0; ticks = 0;
      for (int i = 1; i <= 2200; i++) begin
         if (Tick && first == 0) first = i;
         if (Tick) ticks++;
         Start = 1'b0; Pause = (i >= 300 && i < 350);
         @(negedge ClockIn);
      end
      chk("pause_first_tick", first, 1050);
      chk("pause_tick_count", ticks, 2);

      // Stop+Start in RUN, full-length run, restart from DONE
      cyc(1, 0, 0, 2'b00, 4'd9); idle(3);
      cyc(1, 0, 1, 2'b00, 4'd7); idle(2);
      cyc(1, 0, 0, 2'b00, 4'd15); idle(20);
      cyc(1, 0, 0, 2'b01, 4'd5); idle(3);
      cyc(0, 0, 1, 2'b00, 4'd0); idle(2);

      // Asynchronous reset mid-interval
      cyc(1, 0, 0, 2'b01, 4'd4); idle(200);
      #2 Reset = 1'b1;
      #1 chk("async_reset_outputs", int'({Tick, CounterValue, Busy, Done, State}), 0);
      @(negedge ClockIn); @(negedge ClockIn);
      Reset = 1'b0;
      idle(700);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0,
             ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00, 4'($urandom_range(0, 15)));
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
